dvsd_8216m3_mul: RTL and testbench



---
 rtl/dvsd_8216m3_mul_if.sv | 22 ++
 rtl/dvsd_8216m3_mul.sv | 92 +++++++++
 tb/tb_dvsd_8216m3_mul.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dvsd_8216m3_mul_if.sv
// Operand/product bundle for the 8x8 unsigned multiplier.
// Latency: none (wires only); the product appears one clock after its operands.
// Backpressure: none; the source may present a new pair every cycle.
interface dvsd_8216m3_mul_if;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        in_valid;
  logic [15:0] m;
  logic        out_valid;

  // Operand source drives a/b/in_valid and observes the product.
  modport master (
    output a, b, in_valid,
    input  m, out_valid
  );

  // Multiplier consumes operands and returns the registered product.
  modport slave (
    input  a, b, in_valid,
    output m, out_valid
  );
endinterface

// File: rtl/dvsd_8216m3_mul.sv
// Unsigned 8x8 -> 16 array multiplier built from AND partial products and adder rows.
// Latency: 1 clock (combinational array, then the output register).
// Backpressure: none; accepts a new operand pair every cycle.

// Half adder cell used at the low end of each reduction row.
module dvsd_8216m3_mul_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic co
);
  assign s  = x ^ y;
  assign co = x & y;
endmodule

// Full adder cell used for the carry-propagating body of each row.
module dvsd_8216m3_mul_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);
endmodule

module dvsd_8216m3_mul (
  input  logic                     clock,
  input  logic                     reset,
  dvsd_8216m3_mul_if.slave         bus
);
  // pp[i][j] = a[j] & b[i]: row i is the multiplicand gated by multiplier bit i.
  logic [7:0]  pp  [0:7];
  // acc[i] holds the upper 8 bits of the running sum after row i; bit 0 of
  // each row retires straight into the product since later rows sit above it.
  logic [7:0]  acc [0:7];
  logic [7:0]  sum [1:7];
  logic [8:1]  cy  [1:7];
  logic [15:0] prod;

  genvar gi, gj;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pp_row
      for (gj = 0; gj < 8; gj++) begin : g_pp_col
        assign pp[gi][gj] = bus.a[gj] & bus.b[gi];
      end
    end

    // Row 0 needs no adders: its LSB is final, the rest seeds the accumulator.
    assign prod[0] = pp[0][0];
    assign acc[0]  = {1'b0, pp[0][7:1]};

    // Rows 1..7: ripple-add the next shifted partial product onto the accumulator.
    for (gi = 1; gi < 8; gi++) begin : g_row
      dvsd_8216m3_mul_ha u_ha (
        .x  (pp[gi][0]),
        .y  (acc[gi-1][0]),
        .s  (sum[gi][0]),
        .co (cy[gi][1])
      );
      for (gj = 1; gj < 8; gj++) begin : g_fa
        dvsd_8216m3_mul_fa u_fa (
          .x  (pp[gi][gj]),
          .y  (acc[gi-1][gj]),
          .ci (cy[gi][gj]),
          .s  (sum[gi][gj]),
          .co (cy[gi][gj+1])
        );
      end
      assign prod[gi] = sum[gi][0];
      assign acc[gi]  = {cy[gi][8], sum[gi][7:1]};
    end
  endgenerate

  // The final accumulator is the top byte of the product.
  assign prod[15:8] = acc[7];

  // Output register: capture the product on valid operands, hold it otherwise;
  // reset wins over in_valid and discards any pending product.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.m         <= 16'h0000;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.m <= prod;
      end
    end
  end
endmodule

// File: tb/tb_dvsd_8216m3_mul.sv
// Self-checking bench for the 8x8 array multiplier.
// Latency: expects each product one clock after its operands.
// Backpressure: none; drives operands back-to-back.
module tb_dvsd_8216m3_mul;
  logic clock;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  dvsd_8216m3_mul_if bus ();

  dvsd_8216m3_mul dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: what m/out_valid must be after each edge, from plain arithmetic.
  logic [15:0] mdl_m;
  logic        mdl_v;
  bit          mdl_ok = 0;

  always @(posedge clock) begin
    if (reset) begin
      mdl_m  = 16'h0000;
      mdl_v  = 1'b0;
      mdl_ok = 1;
    end else if (mdl_ok) begin
      mdl_v = bus.in_valid;
      if (bus.in_valid) mdl_m = 16'(int'(bus.a) * int'(bus.b));
    end
  end

  // Cycle-by-cycle comparison against the reference, on the falling edge.
  always @(negedge clock) begin
    if (mdl_ok) begin
      checks++;
      if (bus.m !== mdl_m || bus.out_valid !== mdl_v) begin
        errors++;
        $display("FAIL model_cmp t=%0t: got m=%h v=%b, want m=%h v=%b",
                 $time, bus.m, bus.out_valid, mdl_m, mdl_v);
      end
    end
  end

  // Apply one operand set, let one edge take it, settle just after the edge.
  task automatic step(input logic [7:0] ta, input logic [7:0] tb_, input logic tv, input logic tr);
    bus.a        = ta;
    bus.b        = tb_;
    bus.in_valid = tv;
    reset        = tr;
    @(posedge clock);
    #1;
  endtask

  // Hand-computed expectation; pins both the DUT and the reference model.
  task automatic expect_lit(input string nm, input logic [15:0] em, input logic ev);
    checks++;
    if (bus.m !== em || bus.out_valid !== ev) begin
      errors++;
      $display("FAIL %s: got m=%h v=%b, want m=%h v=%b", nm, bus.m, bus.out_valid, em, ev);
    end
    checks++;
    if (mdl_m !== em || mdl_v !== ev) begin
      errors++;
      $display("FAIL %s_model: got m=%h v=%b, want m=%h v=%b", nm, mdl_m, mdl_v, em, ev);
    end
  endtask

  initial begin
    bus.a = 8'h00; bus.b = 8'h00; bus.in_valid = 1'b0; reset = 1'b1;

    // Reset holds outputs at zero even with valid max operands present.
    step(8'hFF, 8'hFF, 1'b1, 1'b1); expect_lit("reset_1", 16'h0000, 1'b0);
    step(8'hFF, 8'hFF, 1'b1, 1'b1); expect_lit("reset_2", 16'h0000, 1'b0);
    step(8'hFF, 8'hFF, 1'b1, 1'b0); expect_lit("release_max", 16'hFE01, 1'b1);

    // Zeros, identity, extremes and mid-range.
    step(8'd0,   8'd0,   1'b1, 1'b0); expect_lit("zero_zero", 16'h0000, 1'b1);
    step(8'd1,   8'hAB,  1'b1, 1'b0); expect_lit("one_ab",    16'h00AB, 1'b1);
    step(8'hAB,  8'd1,   1'b1, 1'b0); expect_lit("ab_one",    16'h00AB, 1'b1);
    step(8'd0,   8'd200, 1'b1, 1'b0); expect_lit("zero_a",    16'h0000, 1'b1);
    step(8'd255, 8'd255, 1'b1, 1'b0); expect_lit("max_max",   16'hFE01, 1'b1);
    step(8'd150, 8'd150, 1'b1, 1'b0); expect_lit("mid_150",   16'h57E4, 1'b1);
    step(8'd128, 8'd2,   1'b1, 1'b0); expect_lit("msb_shift", 16'h0100, 1'b1);
    step(8'd200, 8'd0,   1'b1, 1'b0); expect_lit("zero_b",    16'h0000, 1'b1);

    // Hold: invalid operands must leave m untouched and drop out_valid.
    step(8'd12,  8'd12,  1'b1, 1'b0); expect_lit("hold_load", 16'd144, 1'b1);
    step(8'd200, 8'd3,   1'b0, 1'b0); expect_lit("hold_keep", 16'd144, 1'b0);
    step(8'd77,  8'd91,  1'b0, 1'b0); expect_lit("hold_keep2", 16'd144, 1'b0);

    // Reset mid-stream discards the pending product.
    step(8'd10, 8'd10, 1'b1, 1'b0); expect_lit("mid_pre",   16'd100, 1'b1);
    step(8'd20, 8'd20, 1'b1, 1'b1); expect_lit("mid_reset", 16'd0,   1'b0);
    step(8'd20, 8'd20, 1'b1, 1'b0); expect_lit("mid_post",  16'd400, 1'b1);

    // Operands changing between edges must not reach m.
    step(8'd3, 8'd7, 1'b1, 1'b0);
    bus.a = 8'd250; bus.b = 8'd250;
    #2;
    expect_lit("between_edges", 16'd21, 1'b1);

    // Random stream, mostly back-to-back valid, checked by the reference.
    for (int k = 0; k < 1000; k++) begin
      step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 7) != 0), 1'b0);
    end

    // Exhaustive sweep of every operand pair, back-to-back.
    for (int x = 0; x < 256; x++) begin
      for (int y = 0; y < 256; y++) begin
        step(8'(x), 8'(y), 1'b1, 1'b0);
      end
    end
    expect_lit("sweep_last", 16'hFE01, 1'b1);

    step(8'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
